// File: rtl/uc_core_param.sv
// Parametrised accumulator microcontroller core: flash fetch with ready handshake,
// 1-cycle-latency SRAM, GPIO input, N registered output ports, zero/carry flags, HALT.
//
// state | meaning
// BOOT  | waiting for flash to report ready; no instruction latched
// FETCH | presenting pc, latching IR when flash_ready is high
// EXEC  | decoding IR; non-memory ops and ST complete here
// MEM   | SRAM read data valid; acc/flags updated for LD/ALU/CMP
// HALT  | frozen until reset
module uc_core_param #(
   parameter int DATA_W  = 8,
   parameter int PC_W    = 12,
   parameter int SRAM_AW = 8,
   parameter int N_OUT   = 4
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic [15:0]               flash_data,
   input  logic                      flash_ready,
   input  logic [DATA_W-1:0]         in_gpio,
   input  logic [DATA_W-1:0]         sram_data_in,
   output logic [PC_W-1:0]           pc_out,
   output logic [SRAM_AW-1:0]        sram_addr,
   output logic                      sram_write_en,
   output logic [DATA_W-1:0]         sram_data_out,
   output logic [N_OUT*DATA_W-1:0]   out_ports,
   output logic                      bootstrapping,
   output logic                      halted,
   output logic [2:0]                cu_state,
   output logic                      zero_flag,
   output logic                      carry_flag
);

   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
                          OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
                          OP_XOR = 4'h8, OP_IN  = 4'h9, OP_OUT = 4'hA, OP_JMP = 4'hB,
                          OP_JZ  = 4'hC, OP_JC  = 4'hD, OP_CMP = 4'hE, OP_HLT = 4'hF;

   state_t                    state_q;
   logic [PC_W-1:0]           pc_q;
   logic [15:0]               ir_q;
   logic [DATA_W-1:0]         acc_q;
   logic                      z_q;
   logic                      c_q;
   logic [N_OUT*DATA_W-1:0]   out_q;

   logic [3:0]                opcode;
   logic [DATA_W-1:0]         imm;
   logic [PC_W-1:0]           pc_inc;
   logic [PC_W-1:0]           pc_target;
   logic [DATA_W:0]           sum;
   logic [DATA_W:0]           diff;
   logic [DATA_W-1:0]         alu_res;
   logic                      alu_c;

   assign opcode    = ir_q[15:12];
   assign imm       = DATA_W'(ir_q[7:0]);
   assign pc_inc    = pc_q + PC_W'(1);
   assign pc_target = PC_W'(ir_q[11:0]);

   // MEM-phase datapath; LD passes m through and keeps C
   always_comb begin
      sum     = {1'b0, acc_q} + {1'b0, sram_data_in};
      diff    = {1'b0, acc_q} - {1'b0, sram_data_in};
      alu_res = acc_q;
      alu_c   = c_q;
      case (opcode)
         OP_LD:  alu_res = sram_data_in;
         OP_ADD: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
         OP_SUB,
         OP_CMP: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
         OP_AND: begin alu_res = acc_q & sram_data_in; alu_c = 1'b0; end
         OP_OR:  begin alu_res = acc_q | sram_data_in; alu_c = 1'b0; end
         OP_XOR: begin alu_res = acc_q ^ sram_data_in; alu_c = 1'b0; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= S_BOOT;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         out_q   <= '0;
      end else begin
         case (state_q)
            S_BOOT: begin
               if (flash_ready) state_q <= S_FETCH;
            end
            S_FETCH: begin
               if (flash_ready) begin
                  ir_q    <= flash_data;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               state_q <= S_FETCH;
               pc_q    <= pc_inc;
               case (opcode)
                  OP_LDI: begin
                     acc_q <= imm;
                     z_q   <= (imm == '0);
                  end
                  OP_IN: begin
                     acc_q <= in_gpio;
                     z_q   <= (in_gpio == '0);
                  end
                  OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
                     state_q <= S_MEM;
                     pc_q    <= pc_q;
                  end
                  // indices at or above N_OUT match no port and are dropped
                  OP_OUT: begin
                     for (int k = 0; k < N_OUT; k++) begin
                        if (ir_q[3:0] == 4'(k)) out_q[k*DATA_W +: DATA_W] <= acc_q;
                     end
                  end
                  OP_JMP: pc_q <= pc_target;
                  OP_JZ:  if (z_q) pc_q <= pc_target;
                  OP_JC:  if (c_q) pc_q <= pc_target;
                  OP_HLT: begin
                     state_q <= S_HALT;
                     pc_q    <= pc_q;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               if (opcode != OP_CMP) acc_q <= alu_res;
               z_q     <= (alu_res == '0);
               c_q     <= alu_c;
               pc_q    <= pc_inc;
               state_q <= S_FETCH;
            end
            S_HALT: ;
            default: state_q <= S_BOOT;
         endcase
      end
   end

   assign pc_out        = pc_q;
   assign sram_addr     = ir_q[SRAM_AW-1:0];
   assign sram_write_en = (state_q == S_EXEC) && (opcode == OP_ST);
   assign sram_data_out = acc_q;
   assign out_ports     = out_q;
   assign bootstrapping = (state_q == S_BOOT);
   assign halted        = (state_q == S_HALT);
   assign cu_state      = state_q;
   assign zero_flag     = z_q;
   assign carry_flag    = c_q;

endmodule
